// File: rtl/btb_update_ctrl_pkg.sv
// Shared widths, FSM encoding and helpers for the BTB update controller.
package btb_update_ctrl_pkg;

   localparam int ADDR_LEN = 32;
   localparam int DATA_LEN = 32;
   localparam int DEPTH    = 4;
   localparam int PTR_LEN  = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
      return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
   endfunction

endpackage

// File: rtl/btb_update_ctrl_if.sv
// EXU update handshake plus BTB write port, bundled for the update controller.
interface btb_update_ctrl_if #(
   parameter int ADDR_LEN = btb_update_ctrl_pkg::ADDR_LEN,
   parameter int DATA_LEN = btb_update_ctrl_pkg::DATA_LEN
);
   logic                upd_valid;
   logic                upd_ready;
   logic [ADDR_LEN-1:0] upd_pc;
   logic [DATA_LEN-1:0] upd_target;
   logic                upd_mispred;
   logic                btb_wvalid;
   logic [ADDR_LEN-1:0] btb_awaddr;
   logic [DATA_LEN-1:0] btb_wdata;

   modport master (
      output upd_valid, upd_pc, upd_target, upd_mispred,
      input  upd_ready, btb_wvalid, btb_awaddr, btb_wdata
   );

   modport slave (
      input  upd_valid, upd_pc, upd_target, upd_mispred,
      output upd_ready, btb_wvalid, btb_awaddr, btb_wdata
   );
endinterface

// File: rtl/btb_update_queue.sv
// DEPTH-entry {pc, target} FIFO with a PC match port (optionally skipping the head)
// and a target overwrite port used for coalescing.
module btb_update_queue #(
   parameter int ADDR_LEN = 32,
   parameter int DATA_LEN = 32,
   parameter int DEPTH    = 4,
   parameter int PTR_LEN  = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                push,
   input  logic [ADDR_LEN-1:0] push_pc,
   input  logic [DATA_LEN-1:0] push_target,
   input  logic                pop,
   input  logic                clear,
   input  logic [ADDR_LEN-1:0] match_pc,
   input  logic                match_skip_head,
   output logic                match_hit,
   output logic [PTR_LEN-1:0]  match_idx,
   input  logic                ovr_en,
   input  logic [PTR_LEN-1:0]  ovr_idx,
   input  logic [DATA_LEN-1:0] ovr_target,
   output logic [ADDR_LEN-1:0] head_pc,
   output logic [DATA_LEN-1:0] head_target,
   output logic [PTR_LEN:0]    count
);

   logic [ADDR_LEN-1:0] pc_mem     [DEPTH];
   logic [DATA_LEN-1:0] target_mem [DEPTH];
   logic [PTR_LEN-1:0]  rd_ptr;
   logic [PTR_LEN-1:0]  wr_ptr;
   logic [DEPTH-1:0]    live;

   assign head_pc     = pc_mem[rd_ptr];
   assign head_target = target_mem[rd_ptr];

   // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
   always_comb begin
      live      = '0;
      match_hit = 1'b0;
      match_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         live[i] = ({1'b0, PTR_LEN'(PTR_LEN'(i) - rd_ptr)} < count);
         if (live[i] && !(match_skip_head && (PTR_LEN'(i) == rd_ptr)) && (pc_mem[i] == match_pc)) begin
            match_hit = 1'b1;
            match_idx = PTR_LEN'(i);
         end
      end
   end

   // NOTE: storage is reset too, because the head drives the BTB address/data outputs directly.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]     <= '0;
            target_mem[i] <= '0;
         end
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (ovr_en)
            target_mem[ovr_idx] <= ovr_target;
         if (push) begin
            pc_mem[wr_ptr]     <= push_pc;
            target_mem[wr_ptr] <= push_target;
         end
         if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + PTR_LEN'(1);
            if (pop)
               rd_ptr <= rd_ptr + PTR_LEN'(1);
            case ({push, pop})
               2'b10:   count <= count + (PTR_LEN+1)'(1);
               2'b01:   count <= count - (PTR_LEN+1)'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: rtl/btb_update_ctrl.sv
// Filters, coalesces and issues resolved-branch updates into the BTB write port.
// Optional BTB_UPD_PERF_EN adds saturating drop/merge/stall counters.
module btb_update_ctrl
   import btb_update_ctrl_pkg::state_t;
   import btb_update_ctrl_pkg::IDLE;
   import btb_update_ctrl_pkg::WRITE;
   import btb_update_ctrl_pkg::sat_inc;
#(
   parameter int ADDR_LEN = btb_update_ctrl_pkg::ADDR_LEN,
   parameter int DATA_LEN = btb_update_ctrl_pkg::DATA_LEN,
   parameter int DEPTH    = btb_update_ctrl_pkg::DEPTH,
   parameter int PTR_LEN  = btb_update_ctrl_pkg::PTR_LEN
) (
   input  logic              clock,
   input  logic              reset,
   btb_update_ctrl_if.slave  bus,
   input  logic              flush,
   input  logic              wr_block,
   output logic              busy
`ifdef BTB_UPD_PERF_EN
   ,
   output logic [31:0]       perf_drop,
   output logic [31:0]       perf_merge,
   output logic [31:0]       perf_stall
`endif
);

   state_t             state;
   state_t             state_next;
   logic [PTR_LEN:0]   count;
   logic [PTR_LEN:0]   count_next;
   logic               accept;
   logic               upd_write;
   logic               match_hit;
   logic [PTR_LEN-1:0] match_idx;
   logic               merge;
   logic               push;
   logic               pop;

   assign bus.upd_ready = (count != (PTR_LEN+1)'(DEPTH));
   assign busy          = (count != '0);
   assign accept        = bus.upd_valid & bus.upd_ready;
   // Correct predictions and anything handshaked during a flush are consumed without effect.
   assign upd_write     = accept & bus.upd_mispred & ~flush;
   assign merge         = upd_write & match_hit;
   assign push          = upd_write & ~match_hit;
   assign pop           = bus.btb_wvalid;

   btb_update_queue #(
      .ADDR_LEN (ADDR_LEN),
      .DATA_LEN (DATA_LEN),
      .DEPTH    (DEPTH),
      .PTR_LEN  (PTR_LEN)
   ) u_queue (
      .clock           (clock),
      .reset           (reset),
      .push            (push),
      .push_pc         (bus.upd_pc),
      .push_target     (bus.upd_target),
      .pop             (pop),
      .clear           (flush),
      .match_pc        (bus.upd_pc),
      .match_skip_head (bus.btb_wvalid),
      .match_hit       (match_hit),
      .match_idx       (match_idx),
      .ovr_en          (merge),
      .ovr_idx         (match_idx),
      .ovr_target      (bus.upd_target),
      .head_pc         (bus.btb_awaddr),
      .head_target     (bus.btb_wdata),
      .count           (count)
   );

   always_comb begin
      count_next = count;
      if (flush)
         count_next = '0;
      else if (push && !pop)
         count_next = count + (PTR_LEN+1)'(1);
      else if (pop && !push)
         count_next = count - (PTR_LEN+1)'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (count_next != '0) state_next = WRITE;
         WRITE:   if (flush || (count_next == '0)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.btb_wvalid = (state == WRITE) && !wr_block;
   end

`ifdef BTB_UPD_PERF_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_drop  <= '0;
         perf_merge <= '0;
         perf_stall <= '0;
      end else begin
         perf_drop  <= sat_inc(perf_drop, accept & ~bus.upd_mispred);
         perf_merge <= sat_inc(perf_merge, merge);
         perf_stall <= sat_inc(perf_stall, (state == WRITE) & wr_block);
      end
   end
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed plus randomized bench for btb_update_ctrl against a queue-based reference model.
module tb_btb_update_ctrl;
   import btb_update_ctrl_pkg::*;

   logic clock = 1'b0;
   logic reset;
   logic flush;
   logic wr_block;
   logic busy;
`ifdef BTB_UPD_PERF_EN
   logic [31:0] perf_drop;
   logic [31:0] perf_merge;
   logic [31:0] perf_stall;
`endif

   btb_update_ctrl_if bus ();

   btb_update_ctrl dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus.slave),
      .flush    (flush),
      .wr_block (wr_block),
      .busy     (busy)
`ifdef BTB_UPD_PERF_EN
      ,
      .perf_drop  (perf_drop),
      .perf_merge (perf_merge),
      .perf_stall (perf_stall)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] target;
   } ent_t;

   ent_t        mq[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   int unsigned m_drop  = 0;
   int unsigned m_merge = 0;
   int unsigned m_stall = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, check outputs against the model, then advance the model at the edge.
   task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic mp, input logic fl, input logic blk);
      logic exp_wv;
      logic acc;
      int   idx;
      @(negedge clock);
      bus.upd_valid   = v;
      bus.upd_pc      = pc;
      bus.upd_target  = tgt;
      bus.upd_mispred = mp;
      flush           = fl;
      wr_block        = blk;
      #1;
      exp_wv = (mq.size() != 0) && !blk;
      acc    = v && (mq.size() != DEPTH);
      check("upd_ready", 64'(bus.upd_ready), 64'(mq.size() != DEPTH));
      check("busy", 64'(busy), 64'(mq.size() != 0));
      check("btb_wvalid", 64'(bus.btb_wvalid), 64'(exp_wv));
      if (exp_wv) begin
         check("btb_awaddr", 64'(bus.btb_awaddr), 64'(mq[0].pc));
         check("btb_wdata", 64'(bus.btb_wdata), 64'(mq[0].target));
      end
      @(posedge clock);
      if (acc && !mp) m_drop++;
      if ((mq.size() != 0) && blk) m_stall++;
      if (fl) begin
         mq.delete();
      end else begin
         if (exp_wv) void'(mq.pop_front());
         if (acc && mp) begin
            idx = -1;
            foreach (mq[i]) if (mq[i].pc == pc) idx = i;
            if (idx >= 0) begin
               mq[idx].target = tgt;
               m_merge++;
            end else begin
               mq.push_back('{pc: pc, target: tgt});
            end
         end
      end
   endtask

   task automatic idle(input logic blk);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, blk);
   endtask

   initial begin
      reset           = 1'b1;
      flush           = 1'b0;
      wr_block        = 1'b0;
      bus.upd_valid   = 1'b0;
      bus.upd_pc      = '0;
      bus.upd_target  = '0;
      bus.upd_mispred = 1'b0;
      #12;
      check("rst_wvalid", 64'(bus.btb_wvalid), 64'(0));
      check("rst_awaddr", 64'(bus.btb_awaddr), 64'(0));
      check("rst_wdata", 64'(bus.btb_wdata), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst_ready", 64'(bus.upd_ready), 64'(1));

      // single update, written the next cycle
      step(1'b1, 32'h8000_0010, 32'h8000_0100, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);

      // correct prediction is dropped
      step(1'b1, 32'h8000_0020, 32'h8000_0200, 1'b0, 1'b0, 1'b0);
      idle(1'b0);

      // fill under block, then drain in order
      for (int i = 0; i < 4; i++)
         step(1'b1, 32'h1000 + 32'(16 * i), 32'h2000 + 32'(i), 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h1100, 32'h2100, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) idle(1'b0);

      // coalesce two updates to the same PC
      step(1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h100, 32'h300, 1'b1, 1'b0, 1'b1);
      idle(1'b1);
      for (int i = 0; i < 3; i++) idle(1'b0);

      // merge skips the head being written: second update allocates anew
      step(1'b1, 32'h140, 32'h400, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h140, 32'h500, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) idle(1'b0);

      // flush with a concurrent update
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'h600 + 32'(4 * i), 32'h900 + 32'(i), 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h700, 32'h701, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) idle(1'b0);

      // randomized traffic with a small PC pool to provoke merges
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) < 7,
              32'h4000 + 32'(4 * $urandom_range(0, 5)),
              $urandom,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 9) < 4);
      end
      for (int i = 0; i < 6; i++) idle(1'b0);

`ifdef BTB_UPD_PERF_EN
      @(negedge clock);
      check("perf_drop", 64'(perf_drop), 64'(m_drop));
      check("perf_merge", 64'(perf_merge), 64'(m_merge));
      check("perf_stall", 64'(perf_stall), 64'(m_stall));
`endif

      // asynchronous reset in the middle of a write cycle
      step(1'b1, 32'hA000, 32'hB000, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      bus.upd_valid = 1'b0;
      wr_block      = 1'b0;
      flush         = 1'b0;
      #1;
      check("pre_rst_wvalid", 64'(bus.btb_wvalid), 64'(1));
      #1;
      reset = 1'b1;
      #1;
      check("async_rst_wvalid", 64'(bus.btb_wvalid), 64'(0));
      check("async_rst_busy", 64'(busy), 64'(0));
`ifdef BTB_UPD_PERF_EN
      check("async_rst_drop", 64'(perf_drop), 64'(0));
      check("async_rst_merge", 64'(perf_merge), 64'(0));
      check("async_rst_stall", 64'(perf_stall), 64'(0));
`endif
      #1;
      reset = 1'b0;
      mq.delete();
      #1;
      check("post_rst_ready", 64'(bus.upd_ready), 64'(1));
      idle(1'b0);
      step(1'b1, 32'hC000, 32'hD000, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
